// File: rtl/rate_ctrl_pkg.sv
// Shared types and constants for the waveform rate controller.
// Imported by the counter datapath and the sequencing top.
package rate_ctrl_pkg;
  localparam int CW        = 28;
  localparam int NUM_RATES = 4;
  localparam int IW        = 2;
  localparam int MIN_DIV   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [IW-1:0] idx_t;
endpackage

// File: rtl/rate_counter.sv
// Period counter: holds the active divisor, flags the last cycle
// of each period and decodes the square clock.
module rate_counter
  import rate_ctrl_pkg::*;
#(
  parameter int          CW      = rate_ctrl_pkg::CW,
  parameter logic [CW-1:0] RST_DIV = CW'(100000000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_run,
  input  logic          i_step,
  input  logic          i_load,
  input  logic [CW-1:0] i_div,
  output logic [CW-1:0] o_div,
  output logic          o_bnd,
  output logic          o_clk
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic [CW-1:0] w_clamp;
  logic          w_bnd;

  assign w_clamp = (i_div < CW'(MIN_DIV)) ? CW'(MIN_DIV) : i_div;
  assign w_bnd   = i_run && (r_cnt == r_div - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_step && !w_bnd) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= RST_DIV;
    end else if (i_load) begin
      r_div <= w_clamp;
    end
  end

  // odd divisors: high floor(div/2), low the remainder
  assign o_clk = i_run && (r_cnt < (r_div >> 1));
  assign o_bnd = w_bnd;
  assign o_div = r_div;

endmodule

// File: rtl/waveform_rate_ctrl.sv
// Rate sequencer: divisor table, manual/sweep index selection,
// dwell counting; divisor changes only land on period boundaries.
module waveform_rate_ctrl
  import rate_ctrl_pkg::*;
#(
  parameter int            CW    = rate_ctrl_pkg::CW,
  parameter logic [CW-1:0] DIV0  = CW'(100000000),
  parameter logic [CW-1:0] DIV1  = CW'(50000000),
  parameter logic [CW-1:0] DIV2  = CW'(25000000),
  parameter logic [CW-1:0] DIV3  = CW'(12500000),
  parameter logic [7:0]    DWELL = 8'd4
) (
  input  logic          clock_in,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          sweep,
  input  logic [1:0]    sel,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic          clock_out,
  output logic          tick,
  output logic [1:0]    cur_index,
  output logic [CW-1:0] cur_div,
  output logic          running
);

  localparam logic [7:0] DWELL_EFF = (DWELL == 8'd0) ? 8'd1 : DWELL;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_tbl [NUM_RATES];
  idx_t          r_index;
  idx_t          w_index_nxt;
  logic [7:0]    r_dwell;
  logic          w_load;
  logic          w_run;
  logic          w_step;
  logic          w_bnd;
  logic          w_dwell_done;

  assign w_run        = (r_state == RUN);
  assign w_step       = w_run && enable;
  assign w_dwell_done = sweep &&
    (({1'b0, r_dwell} + 9'd1) >= {1'b0, DWELL_EFF});

  always_ff @(posedge clock_in) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_index_nxt = r_index;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
          w_index_nxt = sweep ? r_index : sel;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_bnd) begin
          w_load = 1'b1;
          if (!sweep)            w_index_nxt = sel;
          else if (w_dwell_done) w_index_nxt = r_index + idx_t'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!rst_n)      r_index <= '0;
    else if (w_load) r_index <= w_index_nxt;
  end

  always_ff @(posedge clock_in) begin
    if (!rst_n || !w_run || !sweep) begin
      r_dwell <= '0;
    end else if (w_step && w_bnd) begin
      r_dwell <= w_dwell_done ? 8'd0 : r_dwell + 8'd1;
    end
  end

  // load reads the registered entry, so a same-edge write lands next period
  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      r_tbl[0] <= DIV0;
      r_tbl[1] <= DIV1;
      r_tbl[2] <= DIV2;
      r_tbl[3] <= DIV3;
    end else if (wr_en) begin
      r_tbl[wr_addr] <= wr_data;
    end
  end

  rate_counter #(
    .CW      (CW),
    .RST_DIV (DIV0)
  ) u_cnt (
    .clk    (clock_in),
    .rst_n  (rst_n),
    .i_run  (w_run),
    .i_step (w_step),
    .i_load (w_load),
    .i_div  (r_tbl[w_index_nxt]),
    .o_div  (cur_div),
    .o_bnd  (w_bnd),
    .o_clk  (clock_out)
  );

  assign tick      = w_bnd;
  assign cur_index = r_index;
  assign running   = w_run;

endmodule

// File: tb/tb_waveform_rate_ctrl.sv
// Directed bench for waveform_rate_ctrl: period shape, rate change
// timing, sweep order, boundary writes, abort and reset.
module tb_waveform_rate_ctrl;
  localparam int CW = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          sweep = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [CW-1:0] wr_data = '0;
  logic          clock_out;
  logic          tick;
  logic [1:0]    cur_index;
  logic [CW-1:0] cur_div;
  logic          running;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  waveform_rate_ctrl #(.DWELL(8'd2)) dut (
    .clock_in  (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sweep     (sweep),
    .sel       (sel),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clock_out (clock_out),
    .tick      (tick),
    .cur_index (cur_index),
    .cur_div   (cur_div),
    .running   (running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [CW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [32:0] got, exp;
    rst_n = 1'b0; enable = 1'b0;
    step(); step();
    got = {running, clock_out, tick, cur_index, cur_div};
    exp = {3'b000, 2'd0, CW'(100000000)};
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL reset got %h want %h", got, exp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_div6();
    logic [32:0] got, exp;
    int c;
    wr(2'd0, CW'(6));
    sweep = 1'b0; sel = 2'd0; enable = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      c = (k - 1) % 6;
      exp = {1'b1, c < 3, c == 5, 2'd0, CW'(6)};
      got = {running, clock_out, tick, cur_index, cur_div};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL div6 k=%0d got %h want %h", k, got, exp);
      end
    end
    enable = 1'b0;
    step();
    vec++;
    if ({running, clock_out, tick} !== 3'b000) begin
      errs++;
      $display("FAIL div6_stop got %b want 000", {running, clock_out, tick});
    end
  endtask

  task automatic test_div5_clamp();
    logic [32:0] got, exp;
    int c;
    wr(2'd1, CW'(5));
    sel = 2'd1; enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      c = (k - 1) % 5;
      exp = {1'b1, c < 2, c == 4, 2'd1, CW'(5)};
      got = {running, clock_out, tick, cur_index, cur_div};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL div5 k=%0d got %h want %h", k, got, exp);
      end
    end
    enable = 1'b0; step();
    wr(2'd1, CW'(0));
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      c = (k - 1) % 2;
      exp = {1'b1, c < 1, c == 1, 2'd1, CW'(2)};
      got = {running, clock_out, tick, cur_index, cur_div};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL clamp0 k=%0d got %h want %h", k, got, exp);
      end
    end
    enable = 1'b0; step();
    wr(2'd1, CW'(1));
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      c = (k - 1) % 2;
      exp = {1'b1, c < 1, c == 1, 2'd1, CW'(2)};
      got = {running, clock_out, tick, cur_index, cur_div};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL clamp1 k=%0d got %h want %h", k, got, exp);
      end
    end
    enable = 1'b0; step();
  endtask

  task automatic test_sel_change();
    logic [32:0] got, exp;
    int c, d, i;
    wr(2'd1, CW'(4));
    sel = 2'd0; enable = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k <= 6) begin
        c = k - 1; d = 6; i = 0;
      end else begin
        c = (k - 7) % 4; d = 4; i = 1;
      end
      exp = {1'b1, c < d / 2, c == d - 1, 2'(i), CW'(d)};
      got = {running, clock_out, tick, cur_index, cur_div};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL selchg k=%0d got %h want %h", k, got, exp);
      end
      if (k == 2) sel = 2'd1;
    end
    enable = 1'b0; step();
  endtask

  task automatic test_sweep();
    logic [32:0] got, exp;
    int i, d;
    wr(2'd0, CW'(4)); wr(2'd1, CW'(6));
    wr(2'd2, CW'(8)); wr(2'd3, CW'(10));
    sweep = 1'b0; sel = 2'd0; enable = 1'b1; step();
    enable = 1'b0; step();
    sweep = 1'b1; sel = 2'd3; enable = 1'b1;
    for (int p = 0; p < 9; p++) begin
      i = (p / 2) % 4;
      d = 4 + 2 * i;
      for (int c = 0; c < d; c++) begin
        step();
        exp = {1'b1, c < d / 2, c == d - 1, 2'(i), CW'(d)};
        got = {running, clock_out, tick, cur_index, cur_div};
        vec++;
        if (got !== exp) begin
          errs++;
          $display("FAIL sweep p=%0d c=%0d got %h want %h", p, c, got, exp);
        end
      end
    end
    enable = 1'b0; sweep = 1'b0; step();
  endtask

  task automatic test_wr_boundary();
    logic [32:0] got, exp;
    int c, d;
    wr(2'd0, CW'(6));
    sel = 2'd0; sweep = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k <= 12) begin
        c = (k - 1) % 6; d = 6;
      end else begin
        c = k - 13; d = 4;
      end
      exp = {1'b1, c < d / 2, c == d - 1, 2'd0, CW'(d)};
      got = {running, clock_out, tick, cur_index, cur_div};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL wrbnd k=%0d got %h want %h", k, got, exp);
      end
      if (k == 6) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = CW'(4);
      end
      if (k == 7) wr_en = 1'b0;
    end
    enable = 1'b0; step();
  endtask

  task automatic test_abort_reset();
    logic [32:0] got, exp;
    logic [CW-1:0] dv [4];
    dv[0] = CW'(100000000); dv[1] = CW'(50000000);
    dv[2] = CW'(25000000);  dv[3] = CW'(12500000);
    sel = 2'd2; enable = 1'b1;
    step(); step(); step();
    enable = 1'b0;
    step();
    got = {running, clock_out, tick, cur_index, cur_div};
    exp = {3'b000, 2'd2, CW'(8)};
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL abort got %h want %h", got, exp);
    end
    enable = 1'b1; step(); step();
    rst_n = 1'b0; enable = 1'b0;
    step();
    got = {running, clock_out, tick, cur_index, cur_div};
    exp = {3'b000, 2'd0, CW'(100000000)};
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL midrst got %h want %h", got, exp);
    end
    rst_n = 1'b1; step();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); enable = 1'b1;
      step();
      got = {running, clock_out, tick, cur_index, cur_div};
      exp = {3'b110, 2'(s), dv[s]};
      vec++;
      if (got !== exp) begin
        errs++;
        $display("FAIL tblrst s=%0d got %h want %h", s, got, exp);
      end
      enable = 1'b0; step();
    end
  endtask

  initial begin
    test_reset();
    test_div6();
    test_div5_clamp();
    test_sel_change();
    test_sweep();
    test_wr_boundary();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
